// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module  : if_stage_pkg
// Purpose : Shared types and constants for the instruction-fetch stage:
//           reset PC, NOP encoding, FSM state encoding and the buffer entry
//           layout used between if_stage and if_inst_buf.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam logic [63:0] PC_START_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } if_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_inst_buf.sv
// ============================================================================
// Module  : if_inst_buf
// Purpose : DEPTH-entry FIFO of {pc, inst} sitting between instruction
//           memory responses and id_stage.
// Ports   : clk, rst       clock, asynchronous active-high reset
//           flush_i        drop all entries (wins over push/pop)
//           push_i         write push_entry_i at the tail
//           push_entry_i   entry to write
//           pop_i          retire the head entry
//           head_o         head entry (only meaningful when !empty_o)
//           count_o        number of valid entries
//           empty_o/full_o occupancy flags
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module if_inst_buf
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  if_entry_t        push_entry_i,
  input  logic             pop_i,
  output if_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int               PTR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  if_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_C);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Guards make the FIFO robust even if a caller violates occupancy.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Purpose : Instruction-fetch stage. Holds the PC, issues one fetch at a time
//           to instruction memory and buffers responses for id_stage.
//           Redirects reload the PC, flush the buffer and discard any stale
//           response still in flight.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           redirect_valid_i    load redirect_pc_i (bits [1:0] forced to 0)
//           redirect_pc_i       redirect target
//           imem_req_valid_o    fetch request valid
//           imem_req_ready_i    memory accepts the request
//           imem_req_addr_o     fetch address (current PC)
//           imem_resp_valid_i   fetch data valid
//           imem_resp_data_i    fetched instruction word
//           inst_valid_o        buffer head valid toward id_stage
//           inst_ready_i        id_stage consumes the head
//           inst_o              head instruction, NOP when not valid
//           inst_pc_o           head PC, 0 when not valid
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] PC_START  = PC_START_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o
);

  localparam int             CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

  if_state_e        state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      req_pc_q, req_pc_d;

  logic             buf_push;
  logic             buf_pop;
  logic             buf_empty;
  logic             buf_full;
  logic [CNT_W-1:0] buf_count;
  if_entry_t        buf_head;
  if_entry_t        push_entry;

  logic             accept;
  logic             outstanding;
  logic [CNT_W:0]   inflight;

  // Credit: a request is only issued when a buffer slot is guaranteed for
  // its response, counting entries held plus the request in flight.
  assign outstanding      = (state_q == IF_WAIT);
  assign inflight         = {1'b0, buf_count} + {{CNT_W{1'b0}}, outstanding};
  assign imem_req_valid_o = !rst && (state_q == IF_REQ) && !buf_full && (inflight < DEPTH_C);
  assign imem_req_addr_o  = pc_q;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  assign push_entry.pc    = req_pc_q;
  assign push_entry.inst  = imem_resp_data_i;

  assign inst_valid_o     = !buf_empty;
  assign buf_pop          = inst_valid_o && inst_ready_i;
  assign inst_o           = inst_valid_o ? buf_head.inst : INST_NOP;
  assign inst_pc_o        = inst_valid_o ? buf_head.pc   : 64'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IF_REQ;
      pc_q     <= PC_START;
      req_pc_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    buf_push = 1'b0;

    case (state_q)
      IF_REQ: begin
        if (accept) begin
          state_d  = IF_WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
        end
      end
      IF_WAIT: begin
        if (imem_resp_valid_i) begin
          state_d  = IF_REQ;
          buf_push = 1'b1;
        end
      end
      IF_DROP: begin
        if (imem_resp_valid_i) begin
          state_d = IF_REQ;
        end
      end
      default: state_d = IF_REQ;
    endcase

    // Redirect overrides everything: any request already accepted becomes
    // stale, and a response landing in this cycle belongs to the old path.
    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i & ~64'd3;
      buf_push = 1'b0;
      case (state_q)
        IF_REQ:  state_d = accept ? IF_DROP : IF_REQ;
        IF_WAIT: state_d = imem_resp_valid_i ? IF_REQ : IF_DROP;
        IF_DROP: state_d = imem_resp_valid_i ? IF_REQ : IF_DROP;
        default: state_d = IF_REQ;
      endcase
    end
  end

  if_inst_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid_i),
    .push_i       (buf_push),
    .push_entry_i (push_entry),
    .pop_i        (buf_pop),
    .head_o       (buf_head),
    .count_o      (buf_count),
    .empty_o      (buf_empty),
    .full_o       (buf_full)
  );

endmodule

`default_nettype wire
